rx_mcast_dispatch: RTL and testbench

- Per-ingress dispatch controller between an rx-side packet source and the four tx_port arbiters of the switch.
- Accepts one packet at a time and presents it to every tx arbiter whose bit is set in the packet's target mask.
- Tracks which tx ports have granted it, and retires the packet only when all targets are served, giving full multicast/broadcast delivery on top of per-port round-robin arbitration.
- Back-pressures the upstream source while a packet is partially delivered.

---
 rtl/switch_defs.sv | 25 ++
 rtl/sat_counter.sv | 20 ++
 rtl/rx_mcast_dispatch.sv | 137 +++++++++++++
 tb/tb_rx_mcast_dispatch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_defs.sv
// rtl/switch_defs.sv - shared switch types: packet format, port count, counter width, dispatch states
// Exports: NUM_PORTS (from the NUM_PORTS macro, default 4), PTR_W, DATA_W, CNT_W_DEFAULT,
//          packet_t {target, data}, disp_state_t {IDLE, HOLD}.
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif

package switch_defs;

    localparam int NUM_PORTS     = `NUM_PORTS;
    localparam int PTR_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DATA_W        = 16;
    localparam int CNT_W_DEFAULT = 16;

    typedef struct packed {
        logic [NUM_PORTS-1:0] target;   // one bit per tx port
        logic [DATA_W-1:0]    data;
    } packet_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } disp_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, async active-high clear
// Ports: clk, rst (async clear), inc (count enable), cnt (W-bit value, sticks at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_mcast_dispatch.sv
// rtl/rx_mcast_dispatch.sv - per-ingress multicast dispatch: holds one packet until every target tx port grants it
// Ports: clk, rst (async active-high); in_valid/in_pkt/in_ready upstream handshake;
//        rx_valid/rx_pkt toward the tx arbiters (rx_pkt.target = ports still to serve);
//        grants_in (bit j = grant from tx_port j); fwd_cnt/drop_cnt saturating stats; grant_err pulse.
// Optional: define RX_DISPATCH_TIMEOUT_EN to abandon a packet after TIMEOUT_CYCLES hold cycles without completion.
module rx_mcast_dispatch
    import switch_defs::*;
#(
    parameter int PORT_ID        = 0,
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  packet_t              in_pkt,
    output logic                 in_ready,
    output logic                 rx_valid,
    output packet_t              rx_pkt,
    input  logic [NUM_PORTS-1:0] grants_in,
    output logic [CNT_W-1:0]     fwd_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 grant_err
);

    localparam logic [NUM_PORTS-1:0] SELF_BIT = NUM_PORTS'(1) << PORT_ID;

    disp_state_t          state, state_next;
    logic [NUM_PORTS-1:0] remaining;
    logic [DATA_W-1:0]    held_data;
    logic [NUM_PORTS-1:0] eff;
    logic                 done;
    logic                 accept;
    logic                 take;
    logic                 drop_new;
    logic                 retire;
    logic                 timeout_hit;

    // A packet addressed only to ourselves has nowhere to go.
    assign eff  = in_pkt.target & ~SELF_BIT;
    // Grants arriving this cycle finish the packet; in_ready depends on this combinationally
    // so a retiring packet can be replaced on the same edge.
    assign done = ((remaining & ~grants_in) == '0);

`ifdef RX_DISPATCH_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [HOLD_W-1:0] hold_cnt;

    // Fires on the last permitted hold cycle, so rx_valid is seen for exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (state == HOLD) && !done && (hold_cnt == HOLD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (take) begin
            hold_cnt <= '0;
        end else if ((state == HOLD) && !done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            HOLD: begin
                retire   = done;
                in_ready = done || timeout_hit;
            end
            default: in_ready = 1'b0;
        endcase
        accept   = in_valid && in_ready;
        take     = accept && (eff != '0);
        drop_new = accept && (eff == '0);
        if (take) begin
            state_next = HOLD;
        end else if ((state == HOLD) && (done || timeout_hit)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            held_data <= '0;
            rx_valid  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            // remaining is zero while idle, so this also flags any grant seen in IDLE.
            grant_err <= |(grants_in & ~remaining);
            if (take) begin
                remaining <= eff;
                held_data <= in_pkt.data;
                rx_valid  <= 1'b1;
            end else if (state_next == IDLE) begin
                remaining <= '0;
                rx_valid  <= 1'b0;
            end else begin
                remaining <= remaining & ~grants_in;
            end
        end
    end

    always_comb begin
        rx_pkt        = '0;
        rx_pkt.target = remaining;
        rx_pkt.data   = held_data;
    end

    sat_counter #(.W(CNT_W)) u_fwd_cnt (
        .clk (clk),
        .rst (rst),
        .inc (retire),
        .cnt (fwd_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_new || timeout_hit),
        .cnt (drop_cnt)
    );

endmodule

// File: tb/tb_rx_mcast_dispatch.sv
// tb/tb_rx_mcast_dispatch.sv - directed self-checking bench for rx_mcast_dispatch (PORT_ID=1, 4 ports)
module tb_rx_mcast_dispatch;
    import switch_defs::*;

    localparam int TB_CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    packet_t              in_pkt = '0;
    logic                 in_ready;
    logic                 rx_valid;
    packet_t              rx_pkt;
    logic [NUM_PORTS-1:0] grants_in = '0;
    logic [TB_CNT_W-1:0]  fwd_cnt;
    logic [TB_CNT_W-1:0]  drop_cnt;
    logic                 grant_err;

    int total = 0;
    int bad   = 0;

    rx_mcast_dispatch #(
        .PORT_ID        (1),
        .CNT_W          (TB_CNT_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pkt    (in_pkt),
        .in_ready  (in_ready),
        .rx_valid  (rx_valid),
        .rx_pkt    (rx_pkt),
        .grants_in (grants_in),
        .fwd_cnt   (fwd_cnt),
        .drop_cnt  (drop_cnt),
        .grant_err (grant_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] tgt, input logic [15:0] dat);
        in_pkt.target = tgt;
        in_pkt.data   = dat;
        in_valid      = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
        total++; if (rx_pkt !== '0) begin bad++; $display("FAIL reset_rx_pkt got=%0h exp=0", rx_pkt); end
        total++; if (fwd_cnt !== 4'd0) begin bad++; $display("FAIL reset_fwd got=%0d exp=0", fwd_cnt); end
        total++; if (drop_cnt !== 4'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if (grant_err !== 1'b0) begin bad++; $display("FAIL reset_grant_err got=%0b exp=0", grant_err); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_unicast;
        load(4'b0100, 16'h00A1);
        tick;
        in_valid = 1'b0;
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL uni_rx_valid got=%0b exp=1", rx_valid); end
        total++; if (rx_pkt.target !== 4'b0100) begin bad++; $display("FAIL uni_target got=%b exp=0100", rx_pkt.target); end
        total++; if (rx_pkt.data !== 16'h00A1) begin bad++; $display("FAIL uni_data got=%0h exp=a1", rx_pkt.data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL uni_busy got=%0b exp=0", in_ready); end
        grants_in = 4'b0100;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready_on_grant got=%0b exp=1", in_ready); end
        tick;
        grants_in = '0;
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL uni_retired got=%0b exp=0", rx_valid); end
        total++; if (fwd_cnt !== 4'd1) begin bad++; $display("FAIL uni_fwd got=%0d exp=1", fwd_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready_after got=%0b exp=1", in_ready); end
    endtask

    task automatic test_broadcast;
        load(4'b1111, 16'h00B2);
        tick;
        in_valid = 1'b0;
        total++; if (rx_pkt.target !== 4'b1101) begin bad++; $display("FAIL bc_t0 got=%b exp=1101", rx_pkt.target); end
        grants_in = 4'b0001;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_ready0 got=%0b exp=0", in_ready); end
        tick;
        total++; if (rx_pkt.target !== 4'b1100) begin bad++; $display("FAIL bc_t1 got=%b exp=1100", rx_pkt.target); end
        grants_in = 4'b1000;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_ready1 got=%0b exp=0", in_ready); end
        tick;
        total++; if (rx_pkt.target !== 4'b0100) begin bad++; $display("FAIL bc_t2 got=%b exp=0100", rx_pkt.target); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL bc_valid2 got=%0b exp=1", rx_valid); end
        grants_in = 4'b0100;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_ready2 got=%0b exp=1", in_ready); end
        tick;
        grants_in = '0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL bc_retired got=%0b exp=0", rx_valid); end
        total++; if (fwd_cnt !== 4'd2) begin bad++; $display("FAIL bc_fwd got=%0d exp=2", fwd_cnt); end
    endtask

    task automatic test_loopback;
        load(4'b0010, 16'h00C0);
        tick;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL loop_valid got=%0b exp=0", rx_valid); end
        total++; if (drop_cnt !== 4'd1) begin bad++; $display("FAIL loop_drop1 got=%0d exp=1", drop_cnt); end
        load(4'b0000, 16'h00C1);
        tick;
        in_valid = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%0b exp=0", rx_valid); end
        total++; if (drop_cnt !== 4'd2) begin bad++; $display("FAIL empty_drop2 got=%0d exp=2", drop_cnt); end
        total++; if (fwd_cnt !== 4'd2) begin bad++; $display("FAIL loop_fwd got=%0d exp=2", fwd_cnt); end
    endtask

    task automatic test_back_to_back;
        load(4'b0001, 16'h00D1);
        tick;
        load(4'b1000, 16'h00D2);
        grants_in = 4'b0001;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
        tick;
        in_valid  = 1'b0;
        grants_in = '0;
        #1;
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b exp=1", rx_valid); end
        total++; if (rx_pkt.target !== 4'b1000) begin bad++; $display("FAIL b2b_target got=%b exp=1000", rx_pkt.target); end
        total++; if (rx_pkt.data !== 16'h00D2) begin bad++; $display("FAIL b2b_data got=%0h exp=d2", rx_pkt.data); end
        total++; if (fwd_cnt !== 4'd3) begin bad++; $display("FAIL b2b_fwd1 got=%0d exp=3", fwd_cnt); end
        grants_in = 4'b1000;
        tick;
        grants_in = '0;
        total++; if (fwd_cnt !== 4'd4) begin bad++; $display("FAIL b2b_fwd2 got=%0d exp=4", fwd_cnt); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", rx_valid); end
    endtask

    task automatic test_spurious_and_reset;
        load(4'b0100, 16'h00E1);
        tick;
        in_valid  = 1'b0;
        grants_in = 4'b0011;
        tick;
        grants_in = '0;
        total++; if (grant_err !== 1'b1) begin bad++; $display("FAIL spur_err got=%0b exp=1", grant_err); end
        total++; if (rx_pkt.target !== 4'b0100) begin bad++; $display("FAIL spur_target got=%b exp=0100", rx_pkt.target); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL spur_valid got=%0b exp=1", rx_valid); end
        tick;
        total++; if (grant_err !== 1'b0) begin bad++; $display("FAIL spur_pulse got=%0b exp=0", grant_err); end
        rst = 1'b1;
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", rx_valid); end
        total++; if (rx_pkt !== '0) begin bad++; $display("FAIL midrst_pkt got=%0h exp=0", rx_pkt); end
        total++; if (fwd_cnt !== 4'd0) begin bad++; $display("FAIL midrst_fwd got=%0d exp=0", fwd_cnt); end
        total++; if (drop_cnt !== 4'd0) begin bad++; $display("FAIL midrst_drop got=%0d exp=0", drop_cnt); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_idle_grant;
        grants_in = 4'b0001;
        tick;
        grants_in = '0;
        total++; if (grant_err !== 1'b1) begin bad++; $display("FAIL idle_grant_err got=%0b exp=1", grant_err); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL idle_grant_valid got=%0b exp=0", rx_valid); end
    endtask

    task automatic test_timeout;
        int n;
        load(4'b0100, 16'h00F1);
        tick;
        in_valid = 1'b0;
        n = 0;
        while (rx_valid === 1'b1 && n < 120) begin
            n++;
            tick;
        end
`ifdef RX_DISPATCH_TIMEOUT_EN
        total++; if (n !== 8) begin bad++; $display("FAIL to_cycles got=%0d exp=8", n); end
        total++; if (drop_cnt !== 4'd1) begin bad++; $display("FAIL to_drop got=%0d exp=1", drop_cnt); end
        total++; if (fwd_cnt !== 4'd0) begin bad++; $display("FAIL to_fwd got=%0d exp=0", fwd_cnt); end
`else
        total++; if (n !== 120) begin bad++; $display("FAIL hold_cycles got=%0d exp=120", n); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0b exp=1", rx_valid); end
        total++; if (drop_cnt !== 4'd0) begin bad++; $display("FAIL hold_drop got=%0d exp=0", drop_cnt); end
        grants_in = 4'b0100;
        tick;
        grants_in = '0;
        total++; if (fwd_cnt !== 4'd1) begin bad++; $display("FAIL hold_fwd got=%0d exp=1", fwd_cnt); end
`endif
    endtask

    task automatic test_saturation;
        logic [3:0] fwd_before;
        fwd_before = fwd_cnt;
        load(4'b0000, 16'h0000);
        for (int i = 0; i < 20; i++) tick;
        in_valid = 1'b0;
        total++; if (drop_cnt !== 4'hF) begin bad++; $display("FAIL sat_drop got=%0d exp=15", drop_cnt); end
        total++; if (fwd_cnt !== fwd_before) begin bad++; $display("FAIL sat_fwd got=%0d exp=%0d", fwd_cnt, fwd_before); end
    endtask

    initial begin
        test_reset;
        test_unicast;
        test_broadcast;
        test_loopback;
        test_back_to_back;
        test_spurious_and_reset;
        test_idle_grant;
        test_timeout;
        test_saturation;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
